dual_issue_regfile: RTL and testbench

- Architectural GPR file plus LLbit for the dual-issue pipeline.
- Answers the ID-stage register-read request bus: four read ports, two per issue line. The returned old-read bus feeds the ID forwarding/hazard logic.
- Accepts two WB-stage write ports (line1 = older, line2 = younger) and the LLbit update.

---
 rtl/dual_issue_regfile_pkg.sv | 57 +++++
 rtl/dual_issue_regfile_if.sv | 45 ++++
 rtl/dual_issue_regfile_read_port.sv | 57 +++++
 rtl/dual_issue_regfile.sv | 116 +++++++++++
 tb/tb_dual_issue_regfile.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dual_issue_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dual_issue_regfile_pkg
//  Description : Shared constants, bus layouts and helpers for the
//                dual-issue register file and the ID forwarding unit.
//                Optional feature macro: REGFILE_WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package dual_issue_regfile_pkg;

    localparam int unsigned c_REGS_ADDR_WIDTH  = 5;
    localparam int unsigned c_REGS_DATA_WIDTH  = 32;
    localparam int unsigned c_NUM_READ_PORTS   = 4;

    localparam int unsigned c_RADDR_LINE_W     = 12;
    localparam int unsigned c_RADDR_BUS_W      = 24;
    localparam int unsigned c_RDATA_LINE_W     = 65;
    localparam int unsigned c_RDATA_BUS_W      = 130;

    localparam logic        c_WRITE_ENABLE     = 1'b1;

    // One issue line's worth of read requests; port 2 sits above port 1.
    typedef struct packed {
        logic                         re2;
        logic [c_REGS_ADDR_WIDTH-1:0] raddr2;
        logic                         re1;
        logic [c_REGS_ADDR_WIDTH-1:0] raddr1;
    } line_raddr_t;

    // Full read-request bus: line2 in the upper half, line1 in the lower.
    typedef struct packed {
        line_raddr_t l2;
        line_raddr_t l1;
    } raddr_bus_t;

    // Read-data bus: both LLbit copies on top, then data ports line2..line1.
    typedef struct packed {
        logic                         l2_llbit;
        logic                         l1_llbit;
        logic [c_REGS_DATA_WIDTH-1:0] l2_rdata2;
        logic [c_REGS_DATA_WIDTH-1:0] l2_rdata1;
        logic [c_REGS_DATA_WIDTH-1:0] l1_rdata2;
        logic [c_REGS_DATA_WIDTH-1:0] l1_rdata1;
    } rdata_bus_t;

    // True when an active write lands on a readable (nonzero) register.
    function automatic logic addr_hit(
        input logic                         we,
        input logic [c_REGS_ADDR_WIDTH-1:0] waddr,
        input logic [c_REGS_ADDR_WIDTH-1:0] raddr
    );
        return (we == c_WRITE_ENABLE) && (waddr == raddr) &&
               (raddr != '0);
    endfunction

endpackage : dual_issue_regfile_pkg
`default_nettype wire

// File: rtl/dual_issue_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : dual_issue_regfile_if
//  Description : ID read-request/read-data bus plus the two WB write ports
//                and LLbit update of the dual-issue register file.
//  Revision    : 1.0 - initial release
// ============================================================================
import dual_issue_regfile_pkg::*;

interface dual_issue_regfile_if;

    logic [c_RADDR_BUS_W-1:0]     regs_raddr_ibus;
    logic [c_RDATA_BUS_W-1:0]     regs_rdata_obus;

    logic                         l1_wb_we;
    logic [c_REGS_ADDR_WIDTH-1:0] l1_wb_waddr;
    logic [c_REGS_DATA_WIDTH-1:0] l1_wb_wdata;

    logic                         l2_wb_we;
    logic [c_REGS_ADDR_WIDTH-1:0] l2_wb_waddr;
    logic [c_REGS_DATA_WIDTH-1:0] l2_wb_wdata;

    logic                         llbit_we;
    logic                         llbit_wdata;

    // Pipeline side: issues reads and writebacks.
    modport master (
        output regs_raddr_ibus,
        input  regs_rdata_obus,
        output l1_wb_we, l1_wb_waddr, l1_wb_wdata,
        output l2_wb_we, l2_wb_waddr, l2_wb_wdata,
        output llbit_we, llbit_wdata
    );

    // Register file side.
    modport slave (
        input  regs_raddr_ibus,
        output regs_rdata_obus,
        input  l1_wb_we, l1_wb_waddr, l1_wb_wdata,
        input  l2_wb_we, l2_wb_waddr, l2_wb_wdata,
        input  llbit_we, llbit_wdata
    );

endinterface : dual_issue_regfile_if
`default_nettype wire

// File: rtl/dual_issue_regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regs_read_port
//  Description : One combinational GPR read port. Masks disabled reads and
//                r0 to zero; with REGFILE_WB_BYPASS_EN defined it forwards
//                same-cycle WB write data (line2 over line1).
//  Revision    : 1.0 - initial release
// ============================================================================
import dual_issue_regfile_pkg::*;

module regs_read_port #(
    parameter int unsigned DATA_W = c_REGS_DATA_WIDTH,
    parameter int unsigned ADDR_W = c_REGS_ADDR_WIDTH
) (
    input  wire logic              re,
    input  wire logic [ADDR_W-1:0] raddr,
    input  wire logic [DATA_W-1:0] array_rdata,
    input  wire logic              l1_wb_we,
    input  wire logic [ADDR_W-1:0] l1_wb_waddr,
    input  wire logic [DATA_W-1:0] l1_wb_wdata,
    input  wire logic              l2_wb_we,
    input  wire logic [ADDR_W-1:0] l2_wb_waddr,
    input  wire logic [DATA_W-1:0] l2_wb_wdata,
    output logic      [DATA_W-1:0] rdata
);

`ifdef REGFILE_WB_BYPASS_EN
    // Select the youngest in-flight write to this register, else the array.
    always_comb begin
        rdata = '0;
        if (re && (raddr != '0)) begin
            if (addr_hit(l2_wb_we, l2_wb_waddr, raddr)) begin
                rdata = l2_wb_wdata;
            end else if (addr_hit(l1_wb_we, l1_wb_waddr, raddr)) begin
                rdata = l1_wb_wdata;
            end else begin
                rdata = array_rdata;
            end
        end
    end
`else
    // Without bypass the WB ports only matter to the array, not the reads.
    logic w_unused_wb;
    assign w_unused_wb = ^{l1_wb_we, l1_wb_waddr, l1_wb_wdata,
                           l2_wb_we, l2_wb_waddr, l2_wb_wdata};

    // Pre-edge array contents, zeroed for disabled reads and r0.
    always_comb begin
        rdata = '0;
        if (re && (raddr != '0)) begin
            rdata = array_rdata;
        end
    end
`endif

endmodule : regs_read_port
`default_nettype wire

// File: rtl/dual_issue_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : dual_issue_regfile
//  Description : Architectural GPR file and LLbit for the dual-issue
//                pipeline. Four combinational read ports (two per line),
//                two WB write ports (line2 younger, wins collisions).
//                Optional feature macro: REGFILE_WB_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
import dual_issue_regfile_pkg::*;

module dual_issue_regfile #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = c_REGS_DATA_WIDTH,
    parameter int unsigned ADDR_W   = c_REGS_ADDR_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          rst,
    dual_issue_regfile_if.slave bus
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              r_llbit;

    raddr_bus_t        w_raddr_bus;
    rdata_bus_t        w_rdata_bus;
    logic              w_re    [c_NUM_READ_PORTS];
    logic [ADDR_W-1:0] w_raddr [c_NUM_READ_PORTS];
    logic [DATA_W-1:0] w_rdata [c_NUM_READ_PORTS];
    logic              w_llbit;

    assign w_raddr_bus = bus.regs_raddr_ibus;

    // Port order: 0 = l1 port1, 1 = l1 port2, 2 = l2 port1, 3 = l2 port2.
    assign w_re[0]    = w_raddr_bus.l1.re1;
    assign w_raddr[0] = w_raddr_bus.l1.raddr1;
    assign w_re[1]    = w_raddr_bus.l1.re2;
    assign w_raddr[1] = w_raddr_bus.l1.raddr2;
    assign w_re[2]    = w_raddr_bus.l2.re1;
    assign w_raddr[2] = w_raddr_bus.l2.raddr1;
    assign w_re[3]    = w_raddr_bus.l2.re2;
    assign w_raddr[3] = w_raddr_bus.l2.raddr2;

    // GPR array update; line2 is applied last so it wins an address clash.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if ((bus.l1_wb_we == c_WRITE_ENABLE) && (bus.l1_wb_waddr != '0)) begin
                r_regs[bus.l1_wb_waddr] <= bus.l1_wb_wdata;
            end
            if ((bus.l2_wb_we == c_WRITE_ENABLE) && (bus.l2_wb_waddr != '0)) begin
                r_regs[bus.l2_wb_waddr] <= bus.l2_wb_wdata;
            end
        end
    end

    // LLbit update, written by line1 only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_llbit <= 1'b0;
        end else if (bus.llbit_we == c_WRITE_ENABLE) begin
            r_llbit <= bus.llbit_wdata;
        end
    end

    for (genvar gi = 0; gi < c_NUM_READ_PORTS; gi++) begin : g_read_port
        regs_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_read_port (
            .re          (w_re[gi]),
            .raddr       (w_raddr[gi]),
            .array_rdata (r_regs[w_raddr[gi]]),
            .l1_wb_we    (bus.l1_wb_we),
            .l1_wb_waddr (bus.l1_wb_waddr),
            .l1_wb_wdata (bus.l1_wb_wdata),
            .l2_wb_we    (bus.l2_wb_we),
            .l2_wb_waddr (bus.l2_wb_waddr),
            .l2_wb_wdata (bus.l2_wb_wdata),
            .rdata       (w_rdata[gi])
        );
    end

`ifdef REGFILE_WB_BYPASS_EN
    // LLbit seen by ID includes an LLbit update landing this cycle.
    always_comb begin
        w_llbit = r_llbit;
        if (bus.llbit_we == c_WRITE_ENABLE) begin
            w_llbit = bus.llbit_wdata;
        end
    end
`else
    // LLbit seen by ID is the stored value only.
    always_comb begin
        w_llbit = r_llbit;
    end
`endif

    // Pack the read results in the shared bus order.
    always_comb begin
        w_rdata_bus           = '0;
        w_rdata_bus.l2_llbit  = w_llbit;
        w_rdata_bus.l1_llbit  = w_llbit;
        w_rdata_bus.l2_rdata2 = w_rdata[3];
        w_rdata_bus.l2_rdata1 = w_rdata[2];
        w_rdata_bus.l1_rdata2 = w_rdata[1];
        w_rdata_bus.l1_rdata1 = w_rdata[0];
    end

    assign bus.regs_rdata_obus = w_rdata_bus;

endmodule : dual_issue_regfile
`default_nettype wire

// File: tb/tb_dual_issue_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dual_issue_regfile
//  Description : Self-checking bench for dual_issue_regfile: directed cases
//                followed by randomized traffic against an array model.
//                Honours REGFILE_WB_BYPASS_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_regfile;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_issue_regfile_if bus ();

    dual_issue_regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stimulus; port index 0=l1p1, 1=l1p2, 2=l2p1, 3=l2p2.
    logic        re [4];
    logic [4:0]  ra [4];
    logic        w1we, w2we, llwe, llwd;
    logic [4:0]  w1a, w2a;
    logic [31:0] w1d, w2d;

    assign bus.regs_raddr_ibus = {re[3], ra[3], re[2], ra[2],
                                  re[1], ra[1], re[0], ra[0]};
    assign bus.l1_wb_we    = w1we;
    assign bus.l1_wb_waddr = w1a;
    assign bus.l1_wb_wdata = w1d;
    assign bus.l2_wb_we    = w2we;
    assign bus.l2_wb_waddr = w2a;
    assign bus.l2_wb_wdata = w2d;
    assign bus.llbit_we    = llwe;
    assign bus.llbit_wdata = llwd;

    logic [31:0] obs_rd [4];
    logic        obs_ll1, obs_ll2;
    assign obs_rd[0] = bus.regs_rdata_obus[31:0];
    assign obs_rd[1] = bus.regs_rdata_obus[63:32];
    assign obs_rd[2] = bus.regs_rdata_obus[95:64];
    assign obs_rd[3] = bus.regs_rdata_obus[127:96];
    assign obs_ll1   = bus.regs_rdata_obus[128];
    assign obs_ll2   = bus.regs_rdata_obus[129];

    // Reference model: the architectural register contents.
    logic [31:0] model [32];
    logic        model_ll;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input int p);
        if (!re[p] || ra[p] == 5'd0) return 32'd0;
`ifdef REGFILE_WB_BYPASS_EN
        if (w2we && w2a == ra[p]) return w2d;
        if (w1we && w1a == ra[p]) return w1d;
`endif
        return model[ra[p]];
    endfunction

    function automatic logic exp_ll();
`ifdef REGFILE_WB_BYPASS_EN
        if (llwe) return llwd;
`endif
        return model_ll;
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            re[p] = 1'b0;
            ra[p] = 5'd0;
        end
        w1we = 1'b0; w1a = 5'd0; w1d = 32'd0;
        w2we = 1'b0; w2a = 5'd0; w2d = 32'd0;
        llwe = 1'b0; llwd = 1'b0;
    endtask

    task automatic read_all(input logic [4:0] a);
        for (int p = 0; p < 4; p++) begin
            re[p] = 1'b1;
            ra[p] = a;
        end
    endtask

    // Let inputs settle, then compare every output against the model.
    task automatic settle_and_check();
        #1;
        for (int p = 0; p < 4; p++) begin
            check_eq($sformatf("rd%0d", p), obs_rd[p], exp_read(p));
        end
        check_eq("llbit1", {31'd0, obs_ll1}, {31'd0, exp_ll()});
        check_eq("llbit2", {31'd0, obs_ll2}, {31'd0, exp_ll()});
    endtask

    // Clock edge: apply reset or writes to the model in program order.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            model_ll = 1'b0;
        end else begin
            if (w1we && w1a != 5'd0) model[w1a] = w1d;
            if (w2we && w2a != 5'd0) model[w2a] = w2d;
            if (llwe) model_ll = llwd;
        end
        #1;
    endtask

    task automatic step();
        settle_and_check();
        advance();
    endtask

    initial begin
        clear_inputs();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model_ll = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state: everything reads zero.
        read_all(5'd5);
        settle_and_check();
        check_eq("reset_r5", obs_rd[3], 32'd0);

        // Write r5, then reset over a concurrent write.
        clear_inputs();
        w1we = 1'b1; w1a = 5'd5; w1d = 32'hDEADBEEF;
        llwe = 1'b1; llwd = 1'b1;
        step();
        clear_inputs();
        read_all(5'd5);
        w2we = 1'b1; w2a = 5'd6; w2d = 32'h600D;
        rst = 1'b1;
        settle_and_check();
        advance();
        rst = 1'b0;
        clear_inputs();
        read_all(5'd5);
        settle_and_check();
        check_eq("post_reset_r5", obs_rd[0], 32'd0);
        check_eq("post_reset_ll", {31'd0, obs_ll1}, 32'd0);
        ra[1] = 5'd6;
        settle_and_check();
        check_eq("reset_beats_write", obs_rd[1], 32'd0);
        advance();

        // r0 protection.
        clear_inputs();
        w1we = 1'b1; w1a = 5'd0; w1d = 32'h12345678;
        step();
        clear_inputs();
        re[0] = 1'b1; ra[0] = 5'd0;
        settle_and_check();
        check_eq("r0_zero", obs_rd[0], 32'd0);
        advance();

        // Dual write to different registers.
        clear_inputs();
        w1we = 1'b1; w1a = 5'd3; w1d = 32'h11;
        w2we = 1'b1; w2a = 5'd4; w2d = 32'h22;
        step();
        clear_inputs();
        re[1] = 1'b1; ra[1] = 5'd3;
        re[2] = 1'b1; ra[2] = 5'd4;
        settle_and_check();
        check_eq("dual_r3", obs_rd[1], 32'h11);
        check_eq("dual_r4", obs_rd[2], 32'h22);
        advance();

        // Collision: younger line2 wins.
        clear_inputs();
        w1we = 1'b1; w1a = 5'd7; w1d = 32'hAAAA;
        w2we = 1'b1; w2a = 5'd7; w2d = 32'h5555;
        step();
        clear_inputs();
        read_all(5'd7);
        settle_and_check();
        check_eq("collide_r7", obs_rd[3], 32'h5555);
        advance();

        // Same-cycle read of a register being written.
        clear_inputs();
        w1we = 1'b1; w1a = 5'd9; w1d = 32'h1;
        step();
        clear_inputs();
        w2we = 1'b1; w2a = 5'd9; w2d = 32'h99;
        re[3] = 1'b1; ra[3] = 5'd9;
        settle_and_check();
`ifdef REGFILE_WB_BYPASS_EN
        check_eq("same_cycle_r9", obs_rd[3], 32'h99);
`else
        check_eq("same_cycle_r9", obs_rd[3], 32'h1);
`endif
        advance();
        clear_inputs();
        re[3] = 1'b1; ra[3] = 5'd9;
        settle_and_check();
        check_eq("next_cycle_r9", obs_rd[3], 32'h99);
        advance();

        // LLbit set and re masking.
        clear_inputs();
        llwe = 1'b1; llwd = 1'b1;
        ra[0] = 5'd9;
        settle_and_check();
`ifdef REGFILE_WB_BYPASS_EN
        check_eq("ll_same_cycle", {31'd0, obs_ll2}, 32'd1);
`else
        check_eq("ll_same_cycle", {31'd0, obs_ll2}, 32'd0);
`endif
        check_eq("re_mask", obs_rd[0], 32'd0);
        advance();
        clear_inputs();
        settle_and_check();
        check_eq("ll_next_l1", {31'd0, obs_ll1}, 32'd1);
        check_eq("ll_next_l2", {31'd0, obs_ll2}, 32'd1);
        advance();

        // Randomized traffic; addresses biased low to force collisions.
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                re[p] = ($urandom_range(0, 3) != 0);
                ra[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 7));
            end
            w1we = $urandom_range(0, 1) == 1;
            w1a  = 5'($urandom_range(0, 7));
            w1d  = $urandom;
            w2we = $urandom_range(0, 1) == 1;
            w2a  = ($urandom_range(0, 2) == 0) ? w1a : 5'($urandom_range(0, 7));
            w2d  = $urandom;
            llwe = $urandom_range(0, 3) == 0;
            llwd = $urandom_range(0, 1) == 1;
            rst  = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dual_issue_regfile
`default_nettype wire
